// File: rtl/reg_write_pkg.sv
// reg_write_pkg: shared constants and one-hot decode helper for the register write decoder.
package reg_write_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_REGS_DEF = 2**ADDR_W_DEF;
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_REGS = 2**MAX_ADDR_W;
  function automatic logic [MAX_REGS-1:0] onehot_decode(input logic [MAX_ADDR_W-1:0] id, input logic en);
    return en ? (MAX_REGS'(1) << id) : '0;
  endfunction
endpackage

// File: rtl/wdec_onehot_port.sv
// wdec_onehot_port: single-port enable-gated one-hot decoder with optional read-only register 0.
module wdec_onehot_port
  import reg_write_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    id,
  output logic [2**ADDR_W-1:0] vec
);
  logic eff;
  assign eff = en && !(ZERO_REG_RO && id == '0);
  assign vec = (2**ADDR_W)'(onehot_decode(MAX_ADDR_W'(id), eff));
endmodule

// File: rtl/reg_write_wordline_ctrl.sv
// reg_write_wordline_ctrl: multi-port wordline decoder with youngest-port-wins conflict resolution.
// Optional sticky write history (wr_hist/hist_clr) enabled by WDEC_WR_HIST_EN.
module reg_write_wordline_ctrl
  import reg_write_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_PORTS = 2,
  parameter bit ZERO_REG_RO = 1'b1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_PORTS-1:0]           wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]    wr_id,
  output logic [NUM_PORTS*2**ADDR_W-1:0] wordline,
  output logic [2**ADDR_W-1:0]           wordline_any,
  output logic                           conflict,
  output logic [CNT_W-1:0]               conflict_cnt
`ifdef WDEC_WR_HIST_EN
  ,
  input  logic                           hist_clr,
  output logic [2**ADDR_W-1:0]           wr_hist
`endif
);
  localparam int NUM_REGS = 2**ADDR_W;
  logic [NUM_REGS-1:0] dec [NUM_PORTS];
  logic [NUM_REGS-1:0] above;
  logic [NUM_PORTS*NUM_REGS-1:0] wordline_d, wordline_q;
  logic conflict_d, conflict_q, conf;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    wdec_onehot_port #(.ADDR_W(ADDR_W), .ZERO_REG_RO(ZERO_REG_RO)) u_dec (
      .en (wr_en[p]),
      .id (wr_id[p*ADDR_W +: ADDR_W]),
      .vec(dec[p])
    );
  end
  // Walk from the youngest port down so any bit already claimed masks older ports.
  always_comb begin
    above = '0;
    conf = 1'b0;
    wordline_d = '0;
    for (int p = NUM_PORTS-1; p >= 0; p--) begin
      wordline_d[p*NUM_REGS +: NUM_REGS] = flush ? '0 : dec[p] & ~above;
      conf = conf | |(dec[p] & above);
      above = above | dec[p];
    end
    conflict_d = conf && !flush;
    cnt_d = (conflict_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_comb begin
    wordline_any = '0;
    for (int p = 0; p < NUM_PORTS; p++) wordline_any = wordline_any | wordline_q[p*NUM_REGS +: NUM_REGS];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wordline_q <= '0;
      conflict_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wordline_q <= wordline_d;
      conflict_q <= conflict_d;
      cnt_q <= cnt_d;
    end
  end
  assign wordline = wordline_q;
  assign conflict = conflict_q;
  assign conflict_cnt = cnt_q;
`ifdef WDEC_WR_HIST_EN
  logic [NUM_REGS-1:0] any_d, wr_hist_d, wr_hist_q;
  always_comb begin
    any_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) any_d = any_d | wordline_d[p*NUM_REGS +: NUM_REGS];
    wr_hist_d = (hist_clr ? '0 : wr_hist_q) | any_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_hist_q <= '0;
    else wr_hist_q <= wr_hist_d;
  end
  assign wr_hist = wr_hist_q;
`endif
endmodule

// File: tb/tb_reg_write_wordline_ctrl.sv
// tb_reg_write_wordline_ctrl: directed bench for the default decoder and a CNT_W=2, ZERO_REG_RO=0 variant.
module tb_reg_write_wordline_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic hist_clr = 1'b0;
  logic [1:0] wr_en = '0;
  logic [7:0] wr_id = '0;
  logic [31:0] wl_a, wl_s;
  logic [15:0] any_a, any_s;
  logic conf_a, conf_s;
  logic [7:0] cnt_a;
  logic [1:0] cnt_s;
  logic [15:0] hist_a, hist_s;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  reg_write_wordline_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_id(wr_id),
    .wordline(wl_a), .wordline_any(any_a), .conflict(conf_a), .conflict_cnt(cnt_a)
`ifdef WDEC_WR_HIST_EN
    , .hist_clr(hist_clr), .wr_hist(hist_a)
`endif
  );
  reg_write_wordline_ctrl #(.ZERO_REG_RO(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_id(wr_id),
    .wordline(wl_s), .wordline_any(any_s), .conflict(conf_s), .conflict_cnt(cnt_s)
`ifdef WDEC_WR_HIST_EN
    , .hist_clr(hist_clr), .wr_hist(hist_s)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [1:0] en, input logic [3:0] i0, input logic [3:0] i1, input logic fl, input logic hc);
    wr_en = en;
    wr_id = {i1, i0};
    flush = fl;
    hist_clr = hc;
    @(posedge clk);
    #1;
    chk("inv_overlap", {16'h0, wl_a[15:0] & wl_a[31:16]}, 32'h0);
    chk("inv_any_or", {16'h0, any_a}, {16'h0, wl_a[15:0] | wl_a[31:16]});
  endtask
  task automatic chk_a(input string tag, input logic [15:0] w0, input logic [15:0] w1, input logic c, input logic [7:0] n);
    chk({tag, "_wl"}, wl_a, {w1, w0});
    chk({tag, "_any"}, {16'h0, any_a}, {16'h0, w0 | w1});
    chk({tag, "_conf"}, {31'h0, conf_a}, {31'h0, c});
    chk({tag, "_cnt"}, {24'h0, cnt_a}, {24'h0, n});
  endtask
  initial begin
    #12;
    chk_a("reset", 16'h0, 16'h0, 1'b0, 8'd0);
    chk("reset_sat_cnt", {30'h0, cnt_s}, 32'h0);
`ifdef WDEC_WR_HIST_EN
    chk("reset_hist", {16'h0, hist_a}, 32'h0);
`endif
    rst_n = 1'b1;
    step(2'b11, 4'd3, 4'd9, 1'b0, 1'b0);
    chk_a("distinct", 16'h0008, 16'h0200, 1'b0, 8'd0);
    step(2'b11, 4'd5, 4'd5, 1'b0, 1'b0);
    chk_a("conflict", 16'h0000, 16'h0020, 1'b1, 8'd1);
    chk("conflict_sat_cnt", {30'h0, cnt_s}, 32'd1);
    step(2'b00, 4'd5, 4'd5, 1'b0, 1'b0);
    chk_a("idle", 16'h0, 16'h0, 1'b0, 8'd1);
    step(2'b11, 4'd0, 4'd0, 1'b0, 1'b0);
    chk_a("zero_reg", 16'h0, 16'h0, 1'b0, 8'd1);
    chk("zero_rw_wl", wl_s, 32'h0001_0000);
    chk("zero_rw_conf", {31'h0, conf_s}, 32'd1);
    chk("zero_rw_cnt", {30'h0, cnt_s}, 32'd2);
    step(2'b11, 4'd5, 4'd5, 1'b1, 1'b0);
    chk_a("flush", 16'h0, 16'h0, 1'b0, 8'd1);
    chk("flush_sat_cnt", {30'h0, cnt_s}, 32'd2);
    step(2'b10, 4'd15, 4'd15, 1'b0, 1'b0);
    chk_a("single_p1", 16'h0, 16'h8000, 1'b0, 8'd1);
    step(2'b01, 4'd12, 4'd0, 1'b0, 1'b0);
    chk_a("single_p0", 16'h1000, 16'h0, 1'b0, 8'd1);
    step(2'b11, 4'd7, 4'd7, 1'b0, 1'b0);
    chk_a("sat1", 16'h0, 16'h0080, 1'b1, 8'd2);
    chk("sat1_cnt", {30'h0, cnt_s}, 32'd3);
    step(2'b11, 4'd7, 4'd7, 1'b0, 1'b0);
    chk_a("sat2", 16'h0, 16'h0080, 1'b1, 8'd3);
    chk("sat2_cnt", {30'h0, cnt_s}, 32'd3);
    step(2'b11, 4'd1, 4'd1, 1'b0, 1'b0);
    chk_a("sat3", 16'h0, 16'h0002, 1'b1, 8'd4);
    chk("sat3_cnt", {30'h0, cnt_s}, 32'd3);
`ifdef WDEC_WR_HIST_EN
    step(2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("hist_clr_idle", {16'h0, hist_a}, 32'h0);
    step(2'b11, 4'd2, 4'd7, 1'b0, 1'b0);
    chk("hist_2_7", {16'h0, hist_a}, 32'h0084);
    step(2'b01, 4'd4, 4'd0, 1'b0, 1'b1);
    chk("hist_clr_wr4", {16'h0, hist_a}, 32'h0010);
    chk("hist_sat_inst", {16'h0, hist_s}, 32'h0010);
`endif
    step(2'b11, 4'd6, 4'd10, 1'b0, 1'b0);
    chk_a("pre_reset", 16'h0040, 16'h0400, 1'b0, 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_reset", 16'h0, 16'h0, 1'b0, 8'd0);
    chk("async_reset_sat_cnt", {30'h0, cnt_s}, 32'h0);
`ifdef WDEC_WR_HIST_EN
    chk("async_reset_hist", {16'h0, hist_a}, 32'h0);
`endif
    @(posedge clk);
    #1;
    chk_a("held_reset", 16'h0, 16'h0, 1'b0, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_write_wordline_ctrl.md
Name: reg_write_wordline_ctrl

Overview:
- Parametrised, multi-port successor of the register-file write decoder.
- Each cycle it takes NUM_PORTS (enable, register-ID) write requests and decodes each to a one-hot wordline vector.
- It resolves same-register conflicts between ports and registers the result, giving one cycle of latency.
- It keeps a saturating conflict counter. It sits between writeback and the register-file array; its outputs drive the per-register write enables directly.

Parameters:
- ADDR_W, 4, register-ID width; NUM_REGS = 2**ADDR_W (derived, not overridable).
- NUM_PORTS, 2, number of write ports; valid range 1..4.
- ZERO_REG_RO, 1, when 1 register 0 is hardwired and writes to ID 0 are suppressed.
- CNT_W, 8, conflict counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of the requests presented this cycle.
- wr_en  input  NUM_PORTS  per-port write request.
- wr_id  input  NUM_PORTS*ADDR_W  per-port register ID; port p occupies bits [p*ADDR_W +: ADDR_W].
- wordline  output  NUM_PORTS*NUM_REGS  registered per-port one-hot wordline; port p occupies bits [p*NUM_REGS +: NUM_REGS].
- wordline_any  output  NUM_REGS  registered OR of all port wordlines.
- conflict  output  1  registered one-cycle pulse: a conflict was resolved in the aligned cycle.
- conflict_cnt  output  CNT_W  saturating count of conflict cycles.
- wr_hist  output  NUM_REGS  sticky written-register bitmap; present only when WDEC_WR_HIST_EN is defined.
- hist_clr  input  1  clears wr_hist; present only when WDEC_WR_HIST_EN is defined.

Behaviour:
- Reset (rst_n low, asynchronous): wordline, wordline_any, conflict, conflict_cnt and wr_hist all return to 0 immediately and stay 0 until the first rising clk after rst_n rises.
- Decode: a port is "effective" when wr_en[p]=1 and not (ZERO_REG_RO=1 and wr_id[p]==0). An effective port yields a one-hot vector with bit wr_id[p] set; a non-effective port yields all zeros. Decode is combinational.
- Conflict resolution:
  - If two or more effective ports carry the same ID, the highest-indexed port wins (it is youngest in program order).
  - All lower-indexed ports with that ID get a zero vector.
  - Ports with distinct IDs are unaffected.
  - Multiple independent conflicting groups in one cycle still produce a single conflict event.
- Writes to ID 0 under ZERO_REG_RO=1 never count as conflicts. With ZERO_REG_RO=0, register 0 behaves like any other register.
- Pipeline:
  - Resolved vectors are registered on the rising clk edge.
  - Outputs reflect inputs sampled exactly 1 cycle earlier. There is no stall input; the block accepts new requests every cycle.
  - wordline_any is the OR of the registered per-port vectors, so at most one port drives any bit.
- Flush: when flush=1 at a rising edge, the registered wordline, wordline_any and conflict load 0 regardless of wr_en. A conflict in the flushed cycle does not increment conflict_cnt.
- Counter:
  - conflict_cnt increments by 1 on every edge where the registered conflict is loaded as 1.
  - It saturates at 2**CNT_W-1 and holds there.
  - It clears only on reset.
- Invariant: each bit of wordline_any is driven by at most one port in every cycle; verification asserts this.

Optional Feature:
- Macro: WDEC_WR_HIST_EN.
- When defined:
  - The wr_hist and hist_clr ports exist.
  - On each rising edge, wr_hist <= (hist_clr ? 0 : wr_hist) | next registered wordline_any. A write in the clear cycle is therefore captured.
  - Reset value of wr_hist is 0.
- When undefined: neither port exists, no history flops are synthesised, and all other behaviour is identical.

Decomposition:
- Shared package reg_write_pkg holds:
  - default ADDR_W and CNT_W constants;
  - function onehot_decode(id, en) returning the NUM_REGS-wide one-hot vector;
  - localparam NUM_REGS derivation.
- One sub-module, wdec_onehot_port: single-port enable-gated decoder with the zero-register suppression. It is instanced NUM_PORTS times.
- Conflict resolution, pipeline registers, counter and history logic live in the top module.

Test Plan:
- Reset: drive activity, then pull rst_n low mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- Distinct IDs: port0 en, id=3; port1 en, id=9 -> next cycle wordline port0 = 16'h0008, port1 = 16'h0200, wordline_any = 16'h0208, conflict = 0.
- Conflict: both ports id=5 -> next cycle port0 = 0, port1 = 16'h0020, conflict = 1 for one cycle, conflict_cnt 0 -> 1.
- Zero register: ZERO_REG_RO=1 with both ports id=0 -> all wordlines 0, conflict = 0, conflict_cnt unchanged.
- Flush: same-ID conflict presented with flush=1 -> next cycle all outputs 0, conflict_cnt unchanged. Separately, CNT_W=2 with 5 consecutive conflict cycles -> conflict_cnt saturates at 3.
- History (WDEC_WR_HIST_EN defined): writes to IDs 2 and 7, then hist_clr together with a write to ID 4 -> wr_hist reads 16'h0084, then 16'h0010.
